// File: rtl/imm_encoder.sv
// imm_encoder: inverse of the datapath immediate extender.
// Turns a 32-bit constant plus an ImmSrc-style mode into the 24-bit Instr[23:0]
// immediate field, and flags constants that cannot be encoded. Modes 01/10/11
// resolve at the accepting edge; mode 00 walks the rotations one per cycle.
module imm_encoder #(
   parameter int ROT_STEPS = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  imm_src,
   input  logic [31:0] value,
   output logic        busy,
   output logic        done,
   output logic        valid,
   output logic [23:0] inst_field
);

   localparam int RW = (ROT_STEPS > 1) ? $clog2(ROT_STEPS) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [RW-1:0]  r_q, r_d;
   logic           valid_q, valid_d;
   logic [23:0]    field_q, field_d;
   logic [31:0]    value_q;
   logic [31:0]    cand;
   logic           accept;

   // Rotate left; the upper half of the doubled word carries the wrapped bits.
   function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] sh);
      logic [63:0] t;
      t = {v, v} << sh;
      return t[63:32];
   endfunction

   // Mode 01: plain zero-extended 12-bit field.
   function automatic logic [24:0] enc_imm12(input logic [31:0] v);
      logic ok;
      ok = (v[31:12] == 20'd0);
      return ok ? {1'b1, 12'd0, v[11:0]} : 25'd0;
   endfunction

   // Mode 10: word-aligned offset whose top bits are a sign extension of bit 25.
   function automatic logic [24:0] enc_branch(input logic [31:0] v);
      logic ok;
      ok = (v[1:0] == 2'b00) &&
           ((v[31:25] == 7'h00) || (v[31:25] == 7'h7F));
      return ok ? {1'b1, v[25:2]} : 25'd0;
   endfunction

   assign accept = start && (state_q == S_IDLE);
   assign cand   = rol32(value_q, 5'({r_q, 1'b0}));

   // Next-state and result logic: one-cycle modes at acceptance, rotation search otherwise.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      valid_d = valid_q;
      field_d = field_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (imm_src)
                  2'b00: begin
                     state_d = S_SEARCH;
                     r_d     = '0;
                  end
                  2'b01: begin
                     {valid_d, field_d} = enc_imm12(value);
                     state_d            = S_DONE;
                  end
                  2'b10: begin
                     {valid_d, field_d} = enc_branch(value);
                     state_d            = S_DONE;
                  end
                  default: begin
                     valid_d = 1'b0;
                     field_d = 24'd0;
                     state_d = S_DONE;
                  end
               endcase
            end
         end
         S_SEARCH: begin
            // Smallest r is tried first, so the first hit is the preferred encoding.
            if (cand[31:8] == 24'd0) begin
               valid_d = 1'b1;
               field_d = {12'd0, 4'(r_q), cand[7:0]};
               state_d = S_DONE;
            end else if (r_q == RW'(ROT_STEPS - 1)) begin
               valid_d = 1'b0;
               field_d = 24'd0;
               state_d = S_DONE;
            end else begin
               r_d = r_q + RW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and result registers; reset abandons any search in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         valid_q <= 1'b0;
         field_q <= 24'd0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         valid_q <= valid_d;
         field_q <= field_d;
      end
   end

   // Operand capture for the rotation search; only meaningful after acceptance.
   always_ff @(posedge clk) begin
      if (accept) begin
         value_q <= value;
      end
   end

   assign busy       = (state_q == S_SEARCH);
   assign done       = (state_q == S_DONE);
   assign valid      = valid_q;
   assign inst_field = field_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: stimulus pushes expected results and the
// done cycle; a negedge monitor pops and compares on every done pulse.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  imm_src;
   logic [31:0] value;
   logic        busy, done, valid;
   logic [23:0] inst_field;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      string       name;
      logic        v;
      logic [23:0] f;
      int          dcyc;
   } exp_t;

   exp_t sb[$];

   imm_encoder #(.ROT_STEPS(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .imm_src   (imm_src),
      .value     (value),
      .busy      (busy),
      .done      (done),
      .valid     (valid),
      .inst_field(inst_field)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reset_n && done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_valid"}, {31'd0, valid}, {31'd0, e.v});
            chk({e.name, "_field"}, {8'd0, inst_field}, {8'd0, e.f});
            chk({e.name, "_cycle"}, cyc, e.dcyc);
         end
      end
   end

   // Issue one request; lat = cycles from the accepting edge to the done cycle's edge.
   task automatic send(input string name, input logic [1:0] mode, input logic [31:0] val,
                       input logic ev, input logic [23:0] ef, input int lat);
      exp_t e;
      @(negedge clk);
      start   = 1'b1;
      imm_src = mode;
      value   = val;
      e.name  = name;
      e.v     = ev;
      e.f     = ef;
      e.dcyc  = cyc + 1 + lat;
      sb.push_back(e);
      @(negedge clk);
      start   = 1'b0;
      value   = 32'hDEAD_BEEF;
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic run(input string name, input logic [1:0] mode, input logic [31:0] val,
                      input logic ev, input logic [23:0] ef, input int lat);
      send(name, mode, val, ev, ef, lat);
      wait_empty(name);
   endtask

   initial begin
      reset_n = 1'b1;
      start   = 1'b0;
      imm_src = 2'b00;
      value   = 32'd0;
      #3 reset_n = 1'b0;
      #1;
      chk("rst_busy",  {31'd0, busy},  32'd0);
      chk("rst_done",  {31'd0, done},  32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_field", {8'd0, inst_field}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Mode 01
      run("m01_abc",  2'b01, 32'h0000_0ABC, 1'b1, 24'h000ABC, 0);
      run("m01_1000", 2'b01, 32'h0000_1000, 1'b0, 24'h000000, 0);

      // Mode 00
      run("m00_ff",     2'b00, 32'h0000_00FF, 1'b1, 24'h0000FF, 1);
      run("m00_ff000",  2'b00, 32'hFF00_0000, 1'b1, 24'h0004FF, 5);
      run("m00_101",    2'b00, 32'h0000_0101, 1'b0, 24'h000000, 16);
      run("m00_zero",   2'b00, 32'h0000_0000, 1'b1, 24'h000000, 1);
      run("m00_3fc",    2'b00, 32'h0000_03FC, 1'b1, 24'h000FFF, 16);

      // Mode 10
      run("m10_neg8",  2'b10, 32'hFFFF_FFF8, 1'b1, 24'hFFFFFE, 0);
      run("m10_400",   2'b10, 32'h0000_0400, 1'b1, 24'h000100, 0);
      run("m10_2000",  2'b10, 32'h0200_0000, 1'b0, 24'h000000, 0);
      run("m10_6",     2'b10, 32'h0000_0006, 1'b0, 24'h000000, 0);

      // Mode 11 after a valid result: must clear to invalid
      run("m01_pre11", 2'b01, 32'h0000_0123, 1'b1, 24'h000123, 0);
      run("m11",       2'b11, 32'h0000_0000, 1'b0, 24'h000000, 0);

      // start during SEARCH is ignored; exactly one done with the search result
      send("ign", 2'b00, 32'hFF00_0000, 1'b1, 24'h0004FF, 5);
      start   = 1'b1;
      imm_src = 2'b01;
      value   = 32'h0000_0ABC;
      chk("ign_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      start   = 1'b0;
      wait_empty("ign");
      repeat (4) @(negedge clk);

      // Reset mid-search: result from before is wiped, no done is produced
      run("pre_rst", 2'b01, 32'h0000_0ABC, 1'b1, 24'h000ABC, 0);
      @(negedge clk);
      start   = 1'b1;
      imm_src = 2'b00;
      value   = 32'h0000_0101;
      @(negedge clk);
      start   = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_busy",  {31'd0, busy},  32'd1);
      chk("mid_valid_held", {31'd0, valid}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("mrst_busy",  {31'd0, busy},  32'd0);
      chk("mrst_done",  {31'd0, done},  32'd0);
      chk("mrst_valid", {31'd0, valid}, 32'd0);
      chk("mrst_field", {8'd0, inst_field}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      run("post_rst", 2'b00, 32'h0000_0101, 1'b0, 24'h000000, 16);
      run("post_rst2", 2'b00, 32'hFF00_0000, 1'b1, 24'h0004FF, 5);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the datapath immediate extender.
- Takes a 32-bit constant and an ImmSrc-style mode, and produces the 24-bit instruction immediate field that the extender expands back to the same constant. It also flags constants that cannot be encoded.
- Used by the instruction-assembly/self-test path ahead of instruction memory.
- The rotated-imm8 mode runs a multi-cycle search over the 16 rotations, under a start/done handshake.

Parameters:
- ROT_STEPS, 16, number of rotation candidates searched in mode 00 (rotation amount = 2*r, r = 0..ROT_STEPS-1).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- imm_src  input  2  encoding mode: 00 rotated imm8, 01 zero-ext imm12, 10 branch imm24, 11 reserved
- value  input  32  constant to encode; sampled with start
- busy  output  1  high while in SEARCH
- done  output  1  one-cycle pulse; result valid from this cycle until the next accepted start
- valid  output  1  1 = value encodable in requested mode
- inst_field  output  24  encoded Instr[23:0] field; 0 when valid=0

Behaviour:
- Reset (async, reset_n=0): state=IDLE, busy=0, done=0, valid=0, inst_field=0, r=0. Takes effect immediately, including mid-SEARCH; the search is abandoned and no done is issued.
- FSM states: IDLE, SEARCH, DONE.
- Acceptance: start is accepted only in IDLE. On acceptance, value and imm_src are latched. start in SEARCH or DONE is ignored and not queued.
- Modes 01, 10 and 11 resolve in one cycle. At the accepting edge the result is registered and the state goes IDLE->DONE. done=1 for the following cycle, then DONE->IDLE.
- Mode 01: valid = (value[31:12]==0). inst_field = {12'b0, value[11:0]}.
- Mode 10: valid = (value[1:0]==0) and value[31:25] all equal (fits sign-extended 26 bits). inst_field = value[25:2].
- Mode 11: valid=0, inst_field=0.
- Mode 00, search sequence:
  - At the accepting edge: state goes IDLE->SEARCH, r=0.
  - At each SEARCH edge, candidate = ROL(value, 2*r).
  - If candidate[31:8]==0: match. Register valid=1, inst_field = {12'b0, r[3:0], candidate[7:0]}, then go to DONE.
  - Else if r==ROT_STEPS-1: register valid=0, inst_field=0, then go to DONE.
  - Else r<=r+1.
- Mode 00, tie-break: the smallest matching r wins. With r=0 the field is exactly the zero-extended imm8 form, so value 0..255 always encodes with rot=0.
- Mode 00, latency: a match at r gives done high in the cycle after edge E0+r+1, where E0 is the accepting edge. No match gives done after E0+16.
- busy=1 exactly while state=SEARCH. busy=0 in IDLE and DONE.
- valid and inst_field hold their values from DONE until the next accepted start. They are updated only when a result is registered.
- Back-to-back: start may be asserted in the cycle after done (state is IDLE again).

Test Plan:
- Apply reset_n=0 mid-SEARCH on value 0x00000101 mode 00 -> busy, done, valid and inst_field drop to 0 immediately. The next start runs normally from r=0.
- Mode 01:
  - value 0x00000ABC -> done one cycle after the start edge, valid=1, inst_field=0x000ABC.
  - value 0x00001000 -> valid=0, inst_field=0.
- Mode 00:
  - value 0x000000FF -> done after 1 SEARCH cycle, valid=1, inst_field=0x0000FF.
  - value 0xFF000000 -> match at r=4, done after 5 SEARCH cycles, inst_field=0x0004FF.
  - value 0x00000101 -> 16 SEARCH cycles, valid=0, inst_field=0.
- Mode 10:
  - value 0xFFFFFFF8 -> valid=1, inst_field=0xFFFFFE.
  - value 0x00000400 -> inst_field=0x000100.
  - value 0x02000000 -> valid=0.
  - value 0x00000006 -> valid=0.
- Pulse start with mode 01 during a mode-00 SEARCH -> ignored; the original search result is delivered unchanged and exactly one done pulse occurs.
